i2s_rx_deserializer: RTL and testbench

- Receive-side counterpart of the transmit data formatter.
- Oversamples an external I2S bus (sck, ws, sd) in the system clock domain and assembles each channel slot MSB-first.
- Extracts the audio word according to standard / word_size / frame_size and presents it right-aligned and zero-extended on a valid/ready output.
- Sits between the I2S pins and the RX FIFO.

---
 rtl/i2s_rx_deserializer.sv | 249 ++++++++++++++++++++++++
 tb/tb_i2s_rx_deserializer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer.
// Oversamples the external I2S bus (sck, ws, sd) in the clk domain.
// Assembles each channel slot MSB-first.
// Extracts the audio word for the configured standard, word size and frame size.
// Presents the word right-aligned and zero-extended on a valid/ready output.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   en              receiver enable (0 forces IDLE)
//   sck, ws, sd     asynchronous I2S bus inputs
//   standard        00 Philips, 01 right-justified, 10 left-justified, 11 illegal
//   word_size       00 16-bit, 01 24-bit, 10 32-bit, 11 illegal
//   frame_size      0 = 16-bit slot, 1 = 32-bit slot
//   dout, dout_ch   received word and its channel (ws level of the slot)
//   dout_valid      dout holds an unconsumed word
//   dout_ready      consumer accepts dout
//   ovf             pulse: completed word dropped, holding register full
//   err             pulse: illegal config at slot start, or slot cut short
module i2s_rx_deserializer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        sck,
    input  logic        ws,
    input  logic        sd,
    input  logic [1:0]  standard,
    input  logic [1:0]  word_size,
    input  logic        frame_size,
    output logic [31:0] dout,
    output logic        dout_ch,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        ovf,
    output logic        err
);

    localparam int unsigned CNT_W    = 6;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned SLOT_S   = 16;
    localparam int unsigned SLOT_L   = 32;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DELAY,
        RECV,
        WAIT_WS
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
    logic                   sck_s, ws_s, sd_s;
    logic                   sck_d;
    logic                   ws_prev;
    logic                   ws_prev_vld;
    logic                   sck_rise, ws_edge;

    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc, slot_len;
    logic [WORD_W-1:0] sr, sr_n, shifted;
    logic [1:0]        cfg_std, cfg_std_n, cfg_ws, cfg_ws_n;
    logic              cfg_fs, cfg_fs_n;
    logic              slot_ch, slot_ch_n;
    logic              cfg_illegal;
    logic              start_c, capture_c, err_c;

    // Right-align the captured slot according to the slot's latched config.
    function automatic logic [WORD_W-1:0] extract(
        input logic [WORD_W-1:0] s,
        input logic [1:0]        std,
        input logic [1:0]        wsz,
        input logic              fs
    );
        logic [WORD_W-1:0] r;
        r = s;
        if (!fs) begin
            r = {16'b0, s[15:0]};
        end else begin
            case (wsz)
                2'b00:   r = (std == 2'b01) ? {16'b0, s[15:0]} : {16'b0, s[31:16]};
                2'b01:   r = (std == 2'b01) ? {8'b0, s[23:0]}  : {8'b0, s[31:8]};
                default: r = s;
            endcase
        end
        return r;
    endfunction

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign ws_s  = ws_sync[SYNC_STAGES-1];
    assign sd_s  = sd_sync[SYNC_STAGES-1];

    // Input synchronizers; ws_prev is only trusted after one sck_rise since reset,
    // so reset in the middle of a right slot does not look like a ws edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync    <= '0;
            ws_sync     <= '0;
            sd_sync     <= '0;
            sck_d       <= 1'b0;
            ws_prev     <= 1'b0;
            ws_prev_vld <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd};
            sck_d    <= sck_s;
            if (sck_rise) begin
                ws_prev     <= ws_s;
                ws_prev_vld <= 1'b1;
            end
        end
    end

    assign sck_rise    = sck_s & ~sck_d;
    assign ws_edge     = sck_rise & ws_prev_vld & (ws_s != ws_prev);
    assign cfg_illegal = (standard == 2'b11) || (frame_size && (word_size == 2'b11));
    assign slot_len    = cfg_fs ? CNT_W'(SLOT_L) : CNT_W'(SLOT_S);
    assign cnt_inc     = cnt + CNT_W'(1);
    assign shifted     = {sr[WORD_W-2:0], sd_s};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state, slot datapath and capture/err strobes.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sr_n      = sr;
        cfg_std_n = cfg_std;
        cfg_ws_n  = cfg_ws;
        cfg_fs_n  = cfg_fs;
        slot_ch_n = slot_ch;
        start_c   = 1'b0;
        capture_c = 1'b0;
        err_c     = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (en) state_n = SYNC;
            end
            SYNC: begin
                if (ws_edge) start_c = 1'b1;
            end
            DELAY: begin
                if (sck_rise) begin
                    sr_n    = {{(WORD_W-1){1'b0}}, sd_s};
                    cnt_n   = CNT_W'(1);
                    state_n = RECV;
                end
            end
            RECV: begin
                if (sck_rise) begin
                    // Philips LSB coincides with the ws edge; any other edge cuts the slot.
                    if (ws_edge && !((cfg_std == 2'b00) && (cnt_inc == slot_len))) begin
                        err_c   = 1'b1;
                        start_c = 1'b1;
                    end else begin
                        sr_n  = shifted;
                        cnt_n = cnt_inc;
                        if (cnt_inc == slot_len) begin
                            capture_c = 1'b1;
                            if (ws_edge) start_c = 1'b1;
                            else         state_n = WAIT_WS;
                        end
                    end
                end
            end
            WAIT_WS: begin
                if (ws_edge) start_c = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // Slot start: latch config and channel, then branch on the standard.
        if (start_c) begin
            cfg_std_n = standard;
            cfg_ws_n  = word_size;
            cfg_fs_n  = frame_size;
            slot_ch_n = ws_s;
            if (cfg_illegal) begin
                err_c   = 1'b1;
                cnt_n   = '0;
                sr_n    = '0;
                state_n = WAIT_WS;
            end else if (standard == 2'b00) begin
                cnt_n   = '0;
                sr_n    = '0;
                state_n = DELAY;
            end else begin
                cnt_n   = CNT_W'(1);
                sr_n    = {{(WORD_W-1){1'b0}}, sd_s};
                state_n = RECV;
            end
        end

        if (!en) state_n = IDLE;
    end

    // Slot datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            sr      <= '0;
            cfg_std <= 2'b00;
            cfg_ws  <= 2'b00;
            cfg_fs  <= 1'b0;
            slot_ch <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            sr      <= sr_n;
            cfg_std <= cfg_std_n;
            cfg_ws  <= cfg_ws_n;
            cfg_fs  <= cfg_fs_n;
            slot_ch <= slot_ch_n;
        end
    end

    // Output holding register with overflow detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_ch    <= 1'b0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
            err        <= 1'b0;
        end else begin
            ovf <= 1'b0;
            err <= err_c;
            if (capture_c) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= extract(shifted, cfg_std, cfg_ws, cfg_fs);
                    dout_ch    <= slot_ch;
                    dout_valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Self-checking bench for i2s_rx_deserializer.
// Expected words go into exp_q when a slot is sent; accepted DUT words are
// collected into got_q by a monitor and compared in order at the end of each test.
module tb_i2s_rx_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        sck = 1'b0;
    logic        ws = 1'b1;
    logic        sd = 1'b0;
    logic [1:0]  standard = 2'b00;
    logic [1:0]  word_size = 2'b00;
    logic        frame_size = 1'b0;
    logic [31:0] dout;
    logic        dout_ch;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        ovf;
    logic        err;

    int tests = 0;
    int fails = 0;
    int ovf_cnt = 0;
    int err_cnt = 0;
    int rd_idx = 0;
    logic        carry = 1'b0;
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];

    i2s_rx_deserializer #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sck        (sck),
        .ws         (ws),
        .sd         (sd),
        .standard   (standard),
        .word_size  (word_size),
        .frame_size (frame_size),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .ovf        (ovf),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Monitor: record accepted words and count strobe pulses.
    always @(negedge clk) begin
        if (dout_valid && dout_ready) got_q.push_back({dout_ch, dout});
        if (ovf) ovf_cnt++;
        if (err) err_cnt++;
    end

    // One sck period (8 clk); ws/sd change while sck is low.
    task automatic send_bit(input logic w, input logic d);
        ws = w;
        sd = d;
        #40 sck = 1'b1;
        #40 sck = 1'b0;
    endtask

    // Send one slot of nsck clocks, data MSB first; Philips mode delays data by one sck.
    task automatic send_slot(input logic w, input logic [31:0] data, input int nsck, input logic i2s);
        logic [31:0] d;
        d = data;
        for (int i = 0; i < nsck; i++) begin
            if (i2s && i == 0) begin
                send_bit(w, carry);
            end else begin
                send_bit(w, d[31]);
                d = d << 1;
            end
        end
        if (i2s) carry = d[31];
    endtask

    task automatic preamble();
        carry = 1'b0;
        repeat (4) send_bit(1'b1, 1'b0);
    endtask

    task automatic do_reset(input logic [1:0] std, input logic [1:0] wsz, input logic fs);
        standard   = std;
        word_size  = wsz;
        frame_size = fs;
        ws         = 1'b1;
        sd         = 1'b0;
        sck        = 1'b0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rd_idx = got_q.size();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (dout !== 32'h0 || dout_ch !== 1'b0) begin
            fails++;
            $display("FAIL reset_dout: got %h ch%0b, expected 00000000 ch0", dout, dout_ch);
        end
        tests++;
        if (dout_valid !== 1'b0 || ovf !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: got valid=%b ovf=%b err=%b, expected 0 0 0", dout_valid, ovf, err);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_i2s();
        logic [32:0] e;
        do_reset(2'b00, 2'b01, 1'b1);
        preamble();
        exp_q.push_back({1'b0, 32'h00ABCDEF});
        send_slot(1'b0, 32'hABCDEF00, 32, 1'b1);
        exp_q.push_back({1'b1, 32'h00123456});
        send_slot(1'b1, 32'h12345600, 32, 1'b1);
        send_slot(1'b0, 32'h0, 4, 1'b1);
        repeat (20) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (rd_idx >= got_q.size()) begin
                fails++;
                $display("FAIL i2s_word: missing, expected ch%0b %h", e[32], e[31:0]);
            end else begin
                if (got_q[rd_idx] !== e) begin
                    fails++;
                    $display("FAIL i2s_word: got ch%0b %h, expected ch%0b %h", got_q[rd_idx][32], got_q[rd_idx][31:0], e[32], e[31:0]);
                end
                rd_idx++;
            end
        end
        tests++;
        if (got_q.size() != rd_idx) begin
            fails++;
            $display("FAIL i2s_extra: got %0d words, expected %0d", got_q.size(), rd_idx);
        end
    endtask

    task automatic test_rj_lj_frame32();
        logic [32:0] e;
        do_reset(2'b01, 2'b00, 1'b1);
        preamble();
        exp_q.push_back({1'b0, 32'h00001234});
        send_slot(1'b0, 32'h00001234, 32, 1'b0);
        exp_q.push_back({1'b1, 32'h00005678});
        send_slot(1'b1, 32'h00005678, 32, 1'b0);
        repeat (20) @(posedge clk);
        do_reset(2'b10, 2'b00, 1'b1);
        rd_idx = rd_idx - 0;
        preamble();
        exp_q.push_back({1'b0, 32'h00000000});
        send_slot(1'b0, 32'h00001234, 32, 1'b0);
        exp_q.push_back({1'b1, 32'h00000000});
        send_slot(1'b1, 32'h00005678, 32, 1'b0);
        repeat (20) @(posedge clk);
        rd_idx = got_q.size() - 4 >= 0 ? got_q.size() - 4 : 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (rd_idx >= got_q.size()) begin
                fails++;
                $display("FAIL rj_lj_word: missing, expected ch%0b %h", e[32], e[31:0]);
            end else begin
                if (got_q[rd_idx] !== e) begin
                    fails++;
                    $display("FAIL rj_lj_word: got ch%0b %h, expected ch%0b %h", got_q[rd_idx][32], got_q[rd_idx][31:0], e[32], e[31:0]);
                end
                rd_idx++;
            end
        end
        tests++;
        if (got_q.size() != rd_idx) begin
            fails++;
            $display("FAIL rj_lj_extra: got %0d words, expected %0d", got_q.size(), rd_idx);
        end
    endtask

    task automatic test_lj_frame16();
        logic [32:0] e;
        do_reset(2'b10, 2'b00, 1'b0);
        preamble();
        exp_q.push_back({1'b0, 32'h0000BEEF});
        send_slot(1'b0, 32'hBEEF0000, 16, 1'b0);
        exp_q.push_back({1'b1, 32'h0000CAFE});
        send_slot(1'b1, 32'hCAFE0000, 16, 1'b0);
        // Overlong slots: trailing ones must be ignored.
        exp_q.push_back({1'b0, 32'h0000BEEF});
        send_slot(1'b0, 32'hBEEFFFFF, 20, 1'b0);
        exp_q.push_back({1'b1, 32'h0000CAFE});
        send_slot(1'b1, 32'hCAFEFFFF, 20, 1'b0);
        repeat (20) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (rd_idx >= got_q.size()) begin
                fails++;
                $display("FAIL lj16_word: missing, expected ch%0b %h", e[32], e[31:0]);
            end else begin
                if (got_q[rd_idx] !== e) begin
                    fails++;
                    $display("FAIL lj16_word: got ch%0b %h, expected ch%0b %h", got_q[rd_idx][32], got_q[rd_idx][31:0], e[32], e[31:0]);
                end
                rd_idx++;
            end
        end
        tests++;
        if (got_q.size() != rd_idx) begin
            fails++;
            $display("FAIL lj16_extra: got %0d words, expected %0d", got_q.size(), rd_idx);
        end
    endtask

    task automatic test_back_pressure();
        logic [32:0] e;
        int          ovf0;
        dout_ready = 1'b0;
        do_reset(2'b10, 2'b00, 1'b0);
        ovf0 = ovf_cnt;
        preamble();
        exp_q.push_back({1'b0, 32'h00001111});
        send_slot(1'b0, 32'h11110000, 16, 1'b0);
        send_slot(1'b1, 32'h22220000, 16, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        tests++;
        if (dout_valid !== 1'b1 || dout !== 32'h00001111 || dout_ch !== 1'b0) begin
            fails++;
            $display("FAIL bp_held: got valid=%b ch%0b %h, expected valid=1 ch0 00001111", dout_valid, dout_ch, dout);
        end
        tests++;
        if (ovf_cnt - ovf0 != 1) begin
            fails++;
            $display("FAIL bp_ovf: got %0d pulses, expected 1", ovf_cnt - ovf0);
        end
        @(posedge clk);
        #1 dout_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        tests++;
        if (dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_valid_fall: got valid=%b, expected 0", dout_valid);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (rd_idx >= got_q.size()) begin
                fails++;
                $display("FAIL bp_word: missing, expected ch%0b %h", e[32], e[31:0]);
            end else begin
                if (got_q[rd_idx] !== e) begin
                    fails++;
                    $display("FAIL bp_word: got ch%0b %h, expected ch%0b %h", got_q[rd_idx][32], got_q[rd_idx][31:0], e[32], e[31:0]);
                end
                rd_idx++;
            end
        end
        tests++;
        if (got_q.size() != rd_idx) begin
            fails++;
            $display("FAIL bp_extra: got %0d words, expected %0d", got_q.size(), rd_idx);
        end
    endtask

    task automatic test_short_slot();
        logic [32:0] e;
        int          err0;
        do_reset(2'b10, 2'b10, 1'b1);
        err0 = err_cnt;
        preamble();
        send_slot(1'b0, 32'hFFFF0000, 10, 1'b0);
        exp_q.push_back({1'b1, 32'hDEADBEEF});
        send_slot(1'b1, 32'hDEADBEEF, 32, 1'b0);
        repeat (20) @(posedge clk);
        tests++;
        if (err_cnt - err0 != 1) begin
            fails++;
            $display("FAIL short_err: got %0d pulses, expected 1", err_cnt - err0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (rd_idx >= got_q.size()) begin
                fails++;
                $display("FAIL short_word: missing, expected ch%0b %h", e[32], e[31:0]);
            end else begin
                if (got_q[rd_idx] !== e) begin
                    fails++;
                    $display("FAIL short_word: got ch%0b %h, expected ch%0b %h", got_q[rd_idx][32], got_q[rd_idx][31:0], e[32], e[31:0]);
                end
                rd_idx++;
            end
        end
        tests++;
        if (got_q.size() != rd_idx) begin
            fails++;
            $display("FAIL short_extra: got %0d words, expected %0d", got_q.size(), rd_idx);
        end
    endtask

    task automatic test_mid_reset();
        logic [32:0] e;
        int          err0;
        logic [15:0] part;
        do_reset(2'b10, 2'b00, 1'b0);
        preamble();
        part = 16'hA5A5;
        for (int i = 0; i < 7; i++) send_bit(1'b0, part[15-i]);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 7; i < 10; i++) send_bit(1'b0, part[15-i]);
        @(negedge clk);
        tests++;
        if (dout !== 32'h0 || dout_valid !== 1'b0 || err !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL midrst_outputs: got %h valid=%b err=%b ovf=%b, expected all 0", dout, dout_valid, err, ovf);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        err0 = err_cnt;
        rd_idx = got_q.size();
        for (int i = 10; i < 16; i++) send_bit(1'b0, part[15-i]);
        exp_q.push_back({1'b1, 32'h00003333});
        send_slot(1'b1, 32'h33330000, 16, 1'b0);
        exp_q.push_back({1'b0, 32'h00004444});
        send_slot(1'b0, 32'h44440000, 16, 1'b0);
        repeat (20) @(posedge clk);
        tests++;
        if (err_cnt != err0) begin
            fails++;
            $display("FAIL midrst_err: got %0d pulses, expected 0", err_cnt - err0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (rd_idx >= got_q.size()) begin
                fails++;
                $display("FAIL midrst_word: missing, expected ch%0b %h", e[32], e[31:0]);
            end else begin
                if (got_q[rd_idx] !== e) begin
                    fails++;
                    $display("FAIL midrst_word: got ch%0b %h, expected ch%0b %h", got_q[rd_idx][32], got_q[rd_idx][31:0], e[32], e[31:0]);
                end
                rd_idx++;
            end
        end
        tests++;
        if (got_q.size() != rd_idx) begin
            fails++;
            $display("FAIL midrst_extra: got %0d words, expected %0d", got_q.size(), rd_idx);
        end
    endtask

    task automatic test_illegal();
        int err0;
        do_reset(2'b11, 2'b00, 1'b1);
        err0 = err_cnt;
        preamble();
        send_slot(1'b0, 32'h12345678, 32, 1'b0);
        send_slot(1'b1, 32'h9ABCDEF0, 32, 1'b0);
        send_slot(1'b0, 32'h0F0F0F0F, 32, 1'b0);
        repeat (20) @(posedge clk);
        tests++;
        if (err_cnt - err0 != 3) begin
            fails++;
            $display("FAIL illegal_err: got %0d pulses, expected 3", err_cnt - err0);
        end
        tests++;
        if (got_q.size() != rd_idx || dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL illegal_no_output: got %0d words valid=%b, expected 0 words valid=0", got_q.size() - rd_idx, dout_valid);
        end
    endtask

    initial begin
        test_reset();
        test_i2s();
        test_rj_lj_frame32();
        test_lj_frame16();
        test_back_pressure();
        test_short_slot();
        test_mid_reset();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
